// File: rtl/change_dispense_ctrl_if.sv
// Change-request channel between the front-panel logic and the change dispenser.
// Handshake: a request transfers on the rising edge where change_valid and change_ready
// are both 1; the requester holds change_valid and change_amount stable until then.
interface change_dispense_ctrl_if #(
  parameter int AMT_W = 6
);
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic             done;
  logic [AMT_W-1:0] shortfall;

  modport master (
    output change_valid,
    output change_amount,
    input  change_ready,
    input  done,
    input  shortfall
  );

  modport slave (
    input  change_valid,
    input  change_amount,
    output change_ready,
    output done,
    output shortfall
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Coin-return hopper sequencer: pays a change amount in 10- and 5-unit coins,
// confirms each coin on the drop sensor, retries missed drops and latches jams.
module change_dispense_ctrl #(
  parameter int AMT_W       = 6,
  parameter int TUBE_W      = 4,
  parameter int TUBE10_INIT = 8,
  parameter int TUBE5_INIT  = 8,
  parameter int ACK_TIMEOUT = 15,
  parameter int MAX_RETRY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  change_dispense_ctrl_if.slave req,
  output logic                  eject_10,
  output logic                  eject_5,
  input  logic                  coin_sensed,
  input  logic                  refill_10,
  input  logic                  refill_5,
  input  logic                  jam_clear,
  output logic                  busy,
  output logic                  jam,
  output logic [TUBE_W-1:0]     tube10_cnt,
  output logic [TUBE_W-1:0]     tube5_cnt,
  output logic [2:0]            fsm_state
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TUBE_W-1:0] TUBE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    EJECT    = 3'd2,
    WAIT_ACK = 3'd3,
    JAM      = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AMT_W-1:0]  remaining_q;
  logic [AMT_W-1:0]  shortfall_q;
  logic              coin10_q;
  logic [RTY_W-1:0]  retry_q;
  logic [TMR_W-1:0]  timer_q;
  logic [TUBE_W-1:0] tube10_q;
  logic [TUBE_W-1:0] tube5_q;
  logic [AMT_W-1:0]  coin_val;

  logic accept;
  logic pick_10;
  logic pick_5;
  logic finish;
  logic acked;
  logic retry;
  logic to_jam;
  logic clr_jam;
  logic dec10;
  logic dec5;

  assign coin_val = coin10_q ? AMT_W'(10) : AMT_W'(5);
  assign dec10    = acked && coin10_q;
  assign dec5     = acked && !coin10_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    pick_10 = 1'b0;
    pick_5  = 1'b0;
    finish  = 1'b0;
    acked   = 1'b0;
    retry   = 1'b0;
    to_jam  = 1'b0;
    clr_jam = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.change_valid) begin
          accept  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q >= AMT_W'(10) && tube10_q != '0) begin
          pick_10 = 1'b1;
          state_d = EJECT;
        end else if (remaining_q >= AMT_W'(5) && tube5_q != '0) begin
          pick_5  = 1'b1;
          state_d = EJECT;
        end else begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      EJECT: state_d = WAIT_ACK;
      WAIT_ACK: begin
        // The wait spans ACK_TIMEOUT cycles, so re-ejects land ACK_TIMEOUT+1 cycles apart.
        if (coin_sensed) begin
          acked   = 1'b1;
          state_d = SELECT;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry   = 1'b1;
            state_d = EJECT;
          end else begin
            to_jam  = 1'b1;
            state_d = JAM;
          end
        end
      end
      JAM: begin
        if (jam_clear) begin
          clr_jam = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_q <= '0;
      shortfall_q <= '0;
      coin10_q    <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      jam         <= 1'b0;
    end else begin
      if (accept)           remaining_q <= req.change_amount;
      else if (acked)       remaining_q <= remaining_q - coin_val;

      if (accept)                 shortfall_q <= '0;
      else if (finish || clr_jam) shortfall_q <= remaining_q;

      if (pick_10)     coin10_q <= 1'b1;
      else if (pick_5) coin10_q <= 1'b0;

      if (pick_10 || pick_5) retry_q <= '0;
      else if (retry)        retry_q <= retry_q + RTY_W'(1);

      if (state_q == EJECT)         timer_q <= '0;
      else if (state_q == WAIT_ACK) timer_q <= timer_q + TMR_W'(1);

      if (to_jam)       jam <= 1'b1;
      else if (clr_jam) jam <= 1'b0;
    end
  end

  // A refill colliding with a paid coin of the same tube cancels out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tube10_q <= TUBE_W'(TUBE10_INIT);
      tube5_q  <= TUBE_W'(TUBE5_INIT);
    end else begin
      if (dec10 && !refill_10)                            tube10_q <= tube10_q - TUBE_W'(1);
      else if (refill_10 && !dec10 && tube10_q != TUBE_MAX) tube10_q <= tube10_q + TUBE_W'(1);

      if (dec5 && !refill_5)                            tube5_q <= tube5_q - TUBE_W'(1);
      else if (refill_5 && !dec5 && tube5_q != TUBE_MAX) tube5_q <= tube5_q + TUBE_W'(1);
    end
  end

  assign req.change_ready = (state_q == IDLE);
  assign req.done         = (state_q == DONE);
  assign req.shortfall    = shortfall_q;
  assign eject_10         = (state_q == EJECT) && coin10_q;
  assign eject_5          = (state_q == EJECT) && !coin10_q;
  assign busy             = (state_q != IDLE);
  assign tube10_cnt       = tube10_q;
  assign tube5_cnt        = tube5_q;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: table of change requests plus
// hand-written jam, refill, collision and reset sequences.
module tb_change_dispense_ctrl;

  localparam int AMT_W  = 6;
  localparam int TUBE_W = 4;

  logic              clk;
  logic              rst;
  logic              eject_10;
  logic              eject_5;
  logic              coin_sensed;
  logic              refill_10;
  logic              refill_5;
  logic              jam_clear;
  logic              busy;
  logic              jam;
  logic [TUBE_W-1:0] tube10_cnt;
  logic [TUBE_W-1:0] tube5_cnt;
  logic [2:0]        fsm_state;

  change_dispense_ctrl_if #(.AMT_W(AMT_W)) dif ();

  change_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (dif),
    .eject_10   (eject_10),
    .eject_5    (eject_5),
    .coin_sensed(coin_sensed),
    .refill_10  (refill_10),
    .refill_5   (refill_5),
    .jam_clear  (jam_clear),
    .busy       (busy),
    .jam        (jam),
    .tube10_cnt (tube10_cnt),
    .tube5_cnt  (tube5_cnt),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pre_r10;
    int pre_r5;
    int amt;
    int n10;
    int n5;
    int sf;
    int t10;
    int t5;
  } vec_t;

  vec_t       vecs[9];
  logic [3:0] exp_q[$];
  int         ej_cyc[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // driver tasks: all start and end at 1 time unit after a rising edge
  task automatic pulse_refill(input bit ten, input int n);
    for (int i = 0; i < n; i++) begin
      if (ten) refill_10 = 1'b1;
      else     refill_5  = 1'b1;
      @(posedge clk); #1;
      refill_10 = 1'b0;
      refill_5  = 1'b0;
    end
  endtask

  task automatic send_req(input int amt);
    bit ok;
    ok = 1'b0;
    dif.change_valid  = 1'b1;
    dif.change_amount = AMT_W'(amt);
    for (int i = 0; i < 50; i++) begin
      ok = dif.change_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    dif.change_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Watches ejects against exp_q and answers each with coin_sensed ack_dly cycles later
  // (ack_dly 0 = never). Returns on done, or on jam when stop_jam is set.
  task automatic serve(input int ack_dly, input bit stop_jam, input bit refill_on_ack,
                       output bit got_done, output int first_cyc);
    int cnt;
    int cyc;
    int got;
    bit ended;
    cnt = 0;
    cyc = 1;
    got_done = 1'b0;
    ended = 1'b0;
    first_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      cyc++;
      coin_sensed = 1'b0;
      refill_5    = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          coin_sensed = 1'b1;
          if (refill_on_ack) refill_5 = 1'b1;
        end
      end
      if (eject_10 || eject_5) begin
        got = eject_10 ? 10 : 5;
        if (first_cyc < 0) first_cyc = cyc;
        ej_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("extra_coin", got, 0);
        else check("coin_value", got, int'(exp_q.pop_front()));
        if (ack_dly > 0) cnt = ack_dly;
      end
      if (dif.done) begin
        got_done = 1'b1;
        ended = 1'b1;
        break;
      end
      if (stop_jam && jam) begin
        ended = 1'b1;
        break;
      end
    end
    coin_sensed = 1'b0;
    refill_5    = 1'b0;
    if (!ended) check("serve_timeout", 0, 1);
  endtask

  initial begin
    bit got_done;
    int first_cyc;
    int quiet_bad;
    int saw_done;
    bit found;

    vecs[0] = '{0, 0, 25, 2, 1,  0, 6, 7};
    vecs[1] = '{0, 0, 60, 6, 0,  0, 0, 7};
    vecs[2] = '{0, 0, 20, 0, 4,  0, 0, 3};
    vecs[3] = '{0, 0, 15, 0, 3,  0, 0, 0};
    vecs[4] = '{1, 0, 17, 1, 0,  7, 0, 0};
    vecs[5] = '{0, 2,  0, 0, 0,  0, 0, 2};
    vecs[6] = '{0, 0,  3, 0, 0,  3, 0, 2};
    vecs[7] = '{0, 0, 12, 0, 2,  2, 0, 0};
    vecs[8] = '{3, 3, 63, 3, 3, 18, 0, 0};

    rst = 1'b0;
    coin_sensed = 1'b0;
    refill_10 = 1'b0;
    refill_5 = 1'b0;
    jam_clear = 1'b0;
    dif.change_valid = 1'b0;
    dif.change_amount = '0;

    #12;
    check("rst_eject_10", int'(eject_10), 0);
    check("rst_eject_5", int'(eject_5), 0);
    check("rst_done", int'(dif.done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_shortfall", int'(dif.shortfall), 0);
    check("rst_tube10", int'(tube10_cnt), 8);
    check("rst_tube5", int'(tube5_cnt), 8);
    check("rst_ready", int'(dif.change_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // table-driven requests, coin acked 3 cycles after each pulse
    for (int v = 0; v < 9; v++) begin
      pulse_refill(1'b1, vecs[v].pre_r10);
      pulse_refill(1'b0, vecs[v].pre_r5);
      exp_q.delete();
      for (int k = 0; k < vecs[v].n10; k++) exp_q.push_back(4'd10);
      for (int k = 0; k < vecs[v].n5; k++) exp_q.push_back(4'd5);
      send_req(vecs[v].amt);
      serve(3, 1'b0, 1'b0, got_done, first_cyc);
      check("done_seen", int'(got_done), 1);
      check("coins_missing", exp_q.size(), 0);
      if (vecs[v].n10 + vecs[v].n5 > 0) check("first_eject_latency", first_cyc, 2);
      check("shortfall", int'(dif.shortfall), vecs[v].sf);
      check("tube10", int'(tube10_cnt), vecs[v].t10);
      check("tube5", int'(tube5_cnt), vecs[v].t5);
      @(posedge clk); #1;
      check("done_one_cycle", int'(dif.done), 0);
      check("ready_after_done", int'(dif.change_ready), 1);
    end

    // jam: coin never sensed
    pulse_refill(1'b0, 8);
    check("jam_pre_tube5", int'(tube5_cnt), 8);
    exp_q = '{4'd5, 4'd5, 4'd5};
    ej_cyc.delete();
    send_req(5);
    serve(0, 1'b1, 1'b0, got_done, first_cyc);
    check("jam_set", int'(jam), 1);
    check("jam_ready", int'(dif.change_ready), 0);
    check("jam_no_done", int'(got_done), 0);
    check("jam_eject_count", ej_cyc.size(), 3);
    if (ej_cyc.size() == 3) begin
      check("retry_spacing_1", ej_cyc[1] - ej_cyc[0], 16);
      check("retry_spacing_2", ej_cyc[2] - ej_cyc[1], 16);
    end
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (eject_10 || eject_5 || dif.change_ready) quiet_bad++;
    end
    check("jam_quiet", quiet_bad, 0);
    check("jam_sticky", int'(jam), 1);
    jam_clear = 1'b1;
    @(posedge clk); #1;
    jam_clear = 1'b0;
    check("jam_clear_done", int'(dif.done), 1);
    check("jam_clear_flag", int'(jam), 0);
    check("jam_shortfall", int'(dif.shortfall), 5);
    check("jam_tube5", int'(tube5_cnt), 8);
    @(posedge clk); #1;
    check("jam_ready_after", int'(dif.change_ready), 1);

    // refill colliding with a paid 5 coin
    exp_q = '{4'd5};
    send_req(5);
    serve(3, 1'b0, 1'b1, got_done, first_cyc);
    check("collide_done", int'(got_done), 1);
    check("collide_tube5", int'(tube5_cnt), 8);
    check("collide_shortfall", int'(dif.shortfall), 0);
    @(posedge clk); #1;

    // saturation
    pulse_refill(1'b0, 7);
    check("sat_tube5_15", int'(tube5_cnt), 15);
    pulse_refill(1'b0, 1);
    check("sat_tube5_hold", int'(tube5_cnt), 15);

    // stray sensor pulse in IDLE
    coin_sensed = 1'b1;
    @(posedge clk); #1;
    coin_sensed = 1'b0;
    check("stray_tube5", int'(tube5_cnt), 15);
    check("stray_tube10", int'(tube10_cnt), 0);
    check("stray_idle", int'(busy), 0);

    // reset while waiting for a coin
    exp_q = '{4'd5, 4'd5};
    send_req(10);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (eject_5) begin
        found = 1'b1;
        break;
      end
    end
    check("pre_reset_eject", int'(found), 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_eject_5", int'(eject_5), 0);
    check("mid_rst_eject_10", int'(eject_10), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(dif.done), 0);
    check("mid_rst_jam", int'(jam), 0);
    check("mid_rst_shortfall", int'(dif.shortfall), 0);
    check("mid_rst_tube10", int'(tube10_cnt), 8);
    check("mid_rst_tube5", int'(tube5_cnt), 8);
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (dif.done) saw_done++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    if (dif.done) saw_done++;
    check("no_done_on_reset", saw_done, 0);
    exp_q = '{4'd10};
    send_req(10);
    serve(3, 1'b0, 1'b0, got_done, first_cyc);
    check("post_rst_done", int'(got_done), 1);
    check("post_rst_coins", exp_q.size(), 0);
    check("post_rst_shortfall", int'(dif.shortfall), 0);
    check("post_rst_tube10", int'(tube10_cnt), 7);
    check("post_rst_tube5", int'(tube5_cnt), 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
